// File: rtl/cvif_arb_pkg.sv
// ---------------------------------------------------------------------------
// cvif_arb_pkg
//   Shared defaults and small helpers for the CVIF read weighted round-robin
//   arbiter (cvif_rd_wrr_arb) and its rotating-priority picker (cvif_rr_pick).
//   Contents:
//     NUM_REQ / PD_W / WEIGHT_W / OS_W : default configuration
//     src_id_t  : client index type
//     credit_t  : per-turn grant credit type
//     os_cnt_t  : outstanding-read counter type (one bit wider than the limit)
//     wrap_idx  : (base + off) modulo n for base, off < n
// ---------------------------------------------------------------------------
package cvif_arb_pkg;

  localparam int NUM_REQ  = 4;
  localparam int PD_W     = 79;
  localparam int WEIGHT_W = 8;
  localparam int OS_W     = 8;
  localparam int SRC_W    = $clog2(NUM_REQ);

  typedef logic [SRC_W-1:0]    src_id_t;
  typedef logic [WEIGHT_W-1:0] credit_t;
  typedef logic [OS_W:0]       os_cnt_t;

  // Both operands are below n, so a single conditional subtract wraps.
  function automatic int unsigned wrap_idx(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/cvif_rr_pick.sv
// ---------------------------------------------------------------------------
// cvif_rr_pick
//   Combinational rotating-priority find-first. Starting at ptr_i (inclusive)
//   and walking upward with wrap, returns the first set bit of elig_i.
//   Ports:
//     elig_i    in  N   eligible-client mask
//     ptr_i     in  IW  index of the highest-priority client
//     onehot_o  out N   one-hot of the selected client (zero if none)
//     idx_o     out IW  index of the selected client
//     any_o     out 1   at least one client eligible
// ---------------------------------------------------------------------------
module cvif_rr_pick
  import cvif_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // rot[k] is the eligibility of the client k places after the pointer.
  logic [N-1:0]  rot;
  logic [IW-1:0] sel_k;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign rot[gi] = elig_i[IW'(wrap_idx(32'(ptr_i), gi, N))];
    end
  endgenerate

  // Walk downward so the lowest offset (closest to the pointer) wins.
  always_comb begin
    sel_k = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sel_k = IW'(k);
        any_o = 1'b1;
      end
    end
  end

  assign idx_o = IW'(wrap_idx(32'(ptr_i), 32'(sel_k), N));

  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign onehot_o[gi] = any_o & (idx_o == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/cvif_rd_wrr_arb.sv
// ---------------------------------------------------------------------------
// cvif_rd_wrr_arb
//   Weighted round-robin scheduler for CVIF read requests from NUM_REQ DLA
//   clients onto a single read port, with an outstanding-read limit and an
//   idle indication.
//   Ports:
//     nvdla_core_clk    in   1                 clock, rising edge
//     nvdla_core_rst    in   1                 synchronous active-high reset
//     req_pvld          in   NUM_REQ           per-client request valid
//     req_prdy          out  NUM_REQ           per-client ready (one-hot or 0)
//     req_pd            in   NUM_REQ*PD_W      client i at [i*PD_W +: PD_W]
//     reg2dp_rd_weight  in   NUM_REQ*WEIGHT_W  client i weight, 0 = masked
//     reg2dp_rd_os_cnt  in   OS_W              N allows N+1 reads in flight
//     arb_out_pvld      out  1                 granted request valid
//     arb_out_prdy      in   1                 downstream ready
//     arb_out_pd        out  PD_W              granted payload
//     arb_out_src       out  clog2(NUM_REQ)    granted client index
//     rd_rsp_done       in   1                 one read fully returned
//     arb_idle          out  1                 registered idle indication
//     perf_stall_cnt    out  NUM_REQ*32        only with CVIF_ARB_PERF_EN
//   Optional feature macro: CVIF_ARB_PERF_EN adds per-client saturating
//   stall counters; arbitration is identical either way.
// ---------------------------------------------------------------------------
module cvif_rd_wrr_arb #(
  parameter int NUM_REQ  = cvif_arb_pkg::NUM_REQ,
  parameter int PD_W     = cvif_arb_pkg::PD_W,
  parameter int WEIGHT_W = cvif_arb_pkg::WEIGHT_W,
  parameter int OS_W     = cvif_arb_pkg::OS_W
) (
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rst,
  input  logic [NUM_REQ-1:0]           req_pvld,
  output logic [NUM_REQ-1:0]           req_prdy,
  input  logic [NUM_REQ*PD_W-1:0]      req_pd,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  reg2dp_rd_weight,
  input  logic [OS_W-1:0]              reg2dp_rd_os_cnt,
  output logic                         arb_out_pvld,
  input  logic                         arb_out_prdy,
  output logic [PD_W-1:0]              arb_out_pd,
  output logic [$clog2(NUM_REQ)-1:0]   arb_out_src,
  input  logic                         rd_rsp_done,
  output logic                         arb_idle
`ifdef CVIF_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]        perf_stall_cnt
`endif
);

  import cvif_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  // Round-robin state: ptr_q is the client with highest priority; credit_q
  // is the number of further back-to-back grants it may still take.
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d, credit_after;

  logic [OS_W:0]       os_q, os_d, inflight, os_lim;

  logic                stage_vld_q, stage_vld_d;
  logic [PD_W-1:0]     stage_pd_q, stage_pd_d;
  logic [IDX_W-1:0]    stage_src_q, stage_src_d;
  logic                idle_q, idle_d;

  logic [NUM_REQ-1:0]  elig, pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                stage_load, os_room, grant, keep_turn;
  logic                os_inc, os_dec;

  logic [WEIGHT_W-1:0] wt     [NUM_REQ];
  logic [PD_W-1:0]     pd_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_client
      assign wt[gi]     = reg2dp_rd_weight[gi*WEIGHT_W +: WEIGHT_W];
      assign pd_arr[gi] = req_pd[gi*PD_W +: PD_W];
      // A zero weight masks the client regardless of its valid.
      assign elig[gi]   = req_pvld[gi] & (wt[gi] != '0);
    end
  endgenerate

  // The picker searches from the pointer inclusive. When the pointer client
  // is still eligible it is always the pick, so the same index serves both
  // "keep the turn" and "rotate" cases; only the credit handling differs.
  // The pointer is advanced as soon as a turn's credit runs out, which makes
  // the inclusive search equivalent to "first eligible after the old owner".
  cvif_rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick (
    .elig_i   (elig),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign stage_load = ~stage_vld_q | arb_out_prdy;

  // The entry leaving the stage this cycle is counted as in flight so a new
  // grant can never push the outstanding count past limit+1.
  assign inflight = os_q + (OS_W+1)'(stage_vld_q);
  assign os_lim   = {1'b0, reg2dp_rd_os_cnt} + (OS_W+1)'(1);
  assign os_room  = inflight < os_lim;

  assign grant     = ~nvdla_core_rst & stage_load & os_room & pick_any;
  assign keep_turn = elig[ptr_q] & (credit_q != '0);
  assign req_prdy  = grant ? pick_onehot : '0;

  // Grant bookkeeping: credit and pointer.
  always_comb begin
    ptr_d        = ptr_q;
    credit_d     = credit_q;
    credit_after = '0;
    if (grant) begin
      // Weights are only read here, at the start of a new turn.
      if (keep_turn) credit_after = credit_q - WEIGHT_W'(1);
      else           credit_after = wt[pick_idx] - WEIGHT_W'(1);
      if (credit_after == '0) begin
        ptr_d    = IDX_W'(wrap_idx(32'(pick_idx), 1, NUM_REQ));
        credit_d = '0;
      end else begin
        ptr_d    = pick_idx;
        credit_d = credit_after;
      end
    end
  end

  // Output stage and outstanding counter.
  always_comb begin
    stage_vld_d = stage_vld_q;
    stage_pd_d  = stage_pd_q;
    stage_src_d = stage_src_q;
    if (grant) begin
      stage_vld_d = 1'b1;
      stage_pd_d  = pd_arr[pick_idx];
      stage_src_d = pick_idx;
    end else if (arb_out_prdy) begin
      stage_vld_d = 1'b0;
    end

    os_inc = stage_vld_q & arb_out_prdy;
    // A return with nothing outstanding is dropped rather than wrapping.
    os_dec = rd_rsp_done & (os_q != '0);
    case ({os_inc, os_dec})
      2'b10:   os_d = os_q + (OS_W+1)'(1);
      2'b01:   os_d = os_q - (OS_W+1)'(1);
      default: os_d = os_q;
    endcase

    idle_d = ~|req_pvld & ~stage_vld_q & (os_q == '0);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      ptr_q       <= '0;
      credit_q    <= '0;
      os_q        <= '0;
      stage_vld_q <= 1'b0;
      stage_pd_q  <= '0;
      stage_src_q <= '0;
      idle_q      <= 1'b1;
    end else begin
      ptr_q       <= ptr_d;
      credit_q    <= credit_d;
      os_q        <= os_d;
      stage_vld_q <= stage_vld_d;
      stage_pd_q  <= stage_pd_d;
      stage_src_q <= stage_src_d;
      idle_q      <= idle_d;
    end
  end

  assign arb_out_pvld = stage_vld_q;
  assign arb_out_pd   = stage_pd_q;
  assign arb_out_src  = stage_src_q;
  assign arb_idle     = idle_q;

`ifdef CVIF_ARB_PERF_EN
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf
      logic [31:0] stall_cnt_q;
      always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
          stall_cnt_q <= '0;
        end else if (req_pvld[gi] & ~req_prdy[gi] & (stall_cnt_q != '1)) begin
          stall_cnt_q <= stall_cnt_q + 32'd1;
        end
      end
      assign perf_stall_cnt[gi*32 +: 32] = stall_cnt_q;
    end
  endgenerate
`endif

`ifndef SYNTHESIS
  // A response with no read outstanding indicates an upstream accounting bug.
  a_no_os_underflow: assert property (
    @(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
      !(rd_rsp_done && (os_q == '0)));
`endif

endmodule

// File: tb/tb_cvif_rd_wrr_arb.sv
// ---------------------------------------------------------------------------
// tb_cvif_rd_wrr_arb
//   Directed bench for cvif_rd_wrr_arb: a behavioural scheduler model (turn
//   owner + remaining grants + in-flight count) is compared to the DUT on
//   every cycle, and each scenario also checks hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_cvif_rd_wrr_arb;
  import cvif_arb_pkg::*;

  localparam int N  = NUM_REQ;
  localparam int PW = PD_W;
  localparam int WW = WEIGHT_W;

  logic                 nvdla_core_clk = 1'b0;
  logic                 nvdla_core_rst;
  logic [N-1:0]         req_pvld;
  logic [N-1:0]         req_prdy;
  logic [N*PW-1:0]      req_pd;
  logic [N*WW-1:0]      reg2dp_rd_weight;
  logic [OS_W-1:0]      reg2dp_rd_os_cnt;
  logic                 arb_out_pvld;
  logic                 arb_out_prdy;
  logic [PW-1:0]        arb_out_pd;
  src_id_t              arb_out_src;
  logic                 rd_rsp_done;
  logic                 arb_idle;
`ifdef CVIF_ARB_PERF_EN
  logic [N*32-1:0]      perf_stall_cnt;
`endif

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  cvif_rd_wrr_arb dut (
    .nvdla_core_clk   (nvdla_core_clk),
    .nvdla_core_rst   (nvdla_core_rst),
    .req_pvld         (req_pvld),
    .req_prdy         (req_prdy),
    .req_pd           (req_pd),
    .reg2dp_rd_weight (reg2dp_rd_weight),
    .reg2dp_rd_os_cnt (reg2dp_rd_os_cnt),
    .arb_out_pvld     (arb_out_pvld),
    .arb_out_prdy     (arb_out_prdy),
    .arb_out_pd       (arb_out_pd),
    .arb_out_src      (arb_out_src),
    .rd_rsp_done      (rd_rsp_done),
    .arb_idle         (arb_idle)
`ifdef CVIF_ARB_PERF_EN
    ,
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: client whose turn it is; left: grants remaining in that turn.
  // After reset nobody owns a turn, so the search must start at client 0.
  int            m_owner = N - 1;
  int            m_left  = 0;
  int            m_os    = 0;
  bit            m_vld   = 1'b0;
  logic [PW-1:0] m_pd    = '0;
  int            m_src   = 0;
  bit            m_idle  = 1'b1;
  int            m_gq[$];   // model grant order
  int            hs_q[$];   // DUT handshake order
  bit            saw_prdy2 = 1'b0;

  function automatic bit elig(input int c);
    return req_pvld[c] && (reg2dp_rd_weight[c*WW +: WW] != 0);
  endfunction

  // Which client the rules say is granted in the current cycle (-1: none).
  function automatic int model_grant();
    int c;
    if (nvdla_core_rst) return -1;
    if (m_vld && !arb_out_prdy) return -1;
    // Reads in flight after this grant (including the one now leaving)
    // must not exceed limit+1.
    if (m_os + (m_vld ? 1 : 0) + 1 > int'(reg2dp_rd_os_cnt) + 1) return -1;
    if (m_left > 0 && elig(m_owner)) return m_owner;
    for (int i = 1; i <= N; i++) begin
      c = (m_owner + i) % N;
      if (elig(c)) return c;
    end
    return -1;
  endfunction

  initial begin : model_proc
    int g;
    bit hs, dn;
    forever begin
      @(posedge nvdla_core_clk);
      g = model_grant();
      if (nvdla_core_rst) begin
        m_owner = N - 1; m_left = 0; m_os = 0;
        m_vld = 1'b0; m_pd = '0; m_src = 0; m_idle = 1'b1;
      end else begin
        m_idle = (req_pvld == '0) && !m_vld && (m_os == 0);
        hs = m_vld && arb_out_prdy;
        dn = rd_rsp_done && (m_os > 0);
        m_os = m_os + (hs ? 1 : 0) - (dn ? 1 : 0);
        if (g >= 0) begin
          if (g == m_owner && m_left > 0) m_left = m_left - 1;
          else begin
            m_owner = g;
            m_left  = int'(reg2dp_rd_weight[g*WW +: WW]) - 1;
          end
          m_vld = 1'b1;
          m_pd  = req_pd[g*PW +: PW];
          m_src = g;
          m_gq.push_back(g);
        end else if (hs) begin
          m_vld = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare_proc
    int g;
    logic [N-1:0] exp_prdy;
    forever begin
      @(negedge nvdla_core_clk);
      g = model_grant();
      exp_prdy = '0;
      if (g >= 0) exp_prdy[g] = 1'b1;
      chk("req_prdy", req_prdy, exp_prdy);
      chk("arb_out_pvld", arb_out_pvld, m_vld);
      if (m_vld) begin
        chk("arb_out_pd", arb_out_pd, m_pd);
        chk("arb_out_src", arb_out_src, m_src);
      end
      chk("arb_idle", arb_idle, m_idle);
      if (req_prdy[2]) saw_prdy2 = 1'b1;
      if (arb_out_pvld && arb_out_prdy) hs_q.push_back(int'(arb_out_src));
    end
  end

  // ---------------- stimulus ----------------
  task automatic new_payloads();
    logic [95:0] r;
    for (int i = 0; i < N; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      req_pd[i*PW +: PW] = r[PW-1:0];
    end
  endtask

  task automatic step();
    @(posedge nvdla_core_clk);
    #1;
    new_payloads();
  endtask

  task automatic do_reset();
    nvdla_core_rst = 1'b1;
    step();
    step();
    nvdla_core_rst = 1'b0;
    hs_q.delete();
    m_gq.delete();
    saw_prdy2 = 1'b0;
  endtask

  initial begin : main
    int exp1 [8];
    int exp2 [6];
    int cnt2;
    logic [PW-1:0] held_pd;

    exp1 = '{0, 0, 1, 2, 3, 0, 0, 1};
    exp2 = '{0, 1, 3, 0, 1, 3};

    nvdla_core_rst   = 1'b1;
    req_pvld         = '0;
    req_pd           = '0;
    reg2dp_rd_weight = {4{8'd1}};
    reg2dp_rd_os_cnt = 8'd255;
    arb_out_prdy     = 1'b1;
    rd_rsp_done      = 1'b0;
    step();
    @(negedge nvdla_core_clk);
    chk("reset_pvld", arb_out_pvld, 1'b0);
    chk("reset_idle", arb_idle, 1'b1);
    chk("reset_prdy", req_prdy, 4'b0000);
    step();

    // 1: weights {2,1,1,1}
    reg2dp_rd_weight = {8'd1, 8'd1, 8'd1, 8'd2};
    req_pvld = 4'b1111;
    do_reset();
    repeat (12) step();
    chk("t1_len", 32'(hs_q.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < hs_q.size(); i++) begin
      chk("t1_dut_order", hs_q[i], exp1[i]);
      chk("t1_model_order", m_gq[i], exp1[i]);
    end

    // 2: weight[2]=0 masks client 2
    reg2dp_rd_weight = {8'd1, 8'd0, 8'd1, 8'd1};
    do_reset();
    repeat (12) step();
    cnt2 = 0;
    foreach (hs_q[i]) if (hs_q[i] == 2) cnt2++;
    chk("t2_client2_grants", cnt2, 0);
    chk("t2_client2_prdy", saw_prdy2, 1'b0);
    for (int i = 0; i < 6 && i < hs_q.size(); i++) chk("t2_order", hs_q[i], exp2[i]);

    // 3: limit 1 -> two issues then stall; one return -> one more
    reg2dp_rd_weight = {4{8'd1}};
    reg2dp_rd_os_cnt = 8'd1;
    do_reset();
    repeat (8) step();
    chk("t3_issues_before", hs_q.size(), 2);
    rd_rsp_done = 1'b1;
    step();
    rd_rsp_done = 1'b0;
    repeat (6) step();
    chk("t3_issues_after", hs_q.size(), 3);

    // 4: back-pressure holds the stage
    reg2dp_rd_os_cnt = 8'd255;
    arb_out_prdy = 1'b0;
    do_reset();
    held_pd = req_pd[0 +: PW];
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge nvdla_core_clk);
      chk("t4_hold_pvld", arb_out_pvld, 1'b1);
      chk("t4_hold_src", arb_out_src, 2'd0);
      chk("t4_hold_pd", arb_out_pd, held_pd);
      chk("t4_hold_prdy", req_prdy, 4'b0000);
      step();
    end
    arb_out_prdy = 1'b1;
    @(negedge nvdla_core_clk);
    chk("t4_release_prdy", req_prdy, 4'b0010);
    step();
    @(negedge nvdla_core_clk);
    chk("t4_next_src", arb_out_src, 2'd1);
    step();

    // 5: issue and return in the same cycle at 3 outstanding
    req_pvld = 4'b0001;
    do_reset();
    repeat (3) step();
    req_pvld = 4'b0000;
    step();
    req_pvld = 4'b0001;
    step();
    req_pvld = 4'b0000;
    rd_rsp_done = 1'b1;
    step();
    rd_rsp_done = 1'b0;
    chk("t5_issues", hs_q.size(), 4);
    for (int i = 0; i < 2; i++) begin
      rd_rsp_done = 1'b1;
      step();
      rd_rsp_done = 1'b0;
      step();
    end
    @(negedge nvdla_core_clk);
    chk("t5_idle_one_left", arb_idle, 1'b0);
    rd_rsp_done = 1'b1;
    step();
    rd_rsp_done = 1'b0;
    @(negedge nvdla_core_clk);
    chk("t5_idle_lag", arb_idle, 1'b0);
    step();
    @(negedge nvdla_core_clk);
    chk("t5_idle_drained", arb_idle, 1'b1);
    step();

    // 6: reset mid-operation with stage full and 4 outstanding
    req_pvld = 4'b1111;
    do_reset();
    repeat (5) step();
    chk("t6_issues_before", hs_q.size(), 4);
    nvdla_core_rst = 1'b1;
    @(negedge nvdla_core_clk);
    chk("t6_prdy_in_reset", req_prdy, 4'b0000);
    step();
    nvdla_core_rst = 1'b0;
    reg2dp_rd_os_cnt = 8'd0;
    hs_q.delete();
    @(negedge nvdla_core_clk);
    chk("t6_pvld_after", arb_out_pvld, 1'b0);
    chk("t6_idle_after", arb_idle, 1'b1);
    repeat (6) step();
    chk("t6_issues_after", hs_q.size(), 1);
    if (hs_q.size() > 0) chk("t6_first_src", hs_q[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
